unit_hazard_scoreboard: RTL and testbench

//  Parametrised load-use hazard detector for the in-order pipeline.

---
 rtl/unit_hazard_scoreboard.sv | 69 ++++++
 tb/tb_unit_hazard_scoreboard.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/unit_hazard_scoreboard.sv
// Load-use hazard scoreboard: per-register countdown of in-flight load results.
// Combinational stall/issue from state; the ID stage is held while a used source is pending.
module unit_hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_memread,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int SBW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam logic [SBW-1:0] LAT = SBW'(LOAD_LAT);
  localparam logic [SBW-1:0] ONE = SBW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SBW-1:0] sb [NUM_REGS];
  logic rsHazard;
  logic rtHazard;
  logic loadIssue;

  function automatic logic isZeroReg(input logic [REG_ADDR_W-1:0] r);
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  always_comb begin
    rsHazard = id_rs_used && (sb[id_rs] != '0) && !isZeroReg(id_rs);
    rtHazard = id_rt_used && (sb[id_rt] != '0) && !isZeroReg(id_rt);
  end

  assign stall     = id_valid && !flush && (rsHazard || rtHazard);
  assign issue     = id_valid && !flush && !stall;
  // With zero latency the result is always forwardable, so nothing is ever tracked.
  assign loadIssue = issue && id_memread && !isZeroReg(id_rd) && (LOAD_LAT != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) sb[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sb[i] != '0) begin
          // A full count means the load entered ID/EX last cycle and is being squashed.
          if (flush && sb[i] == LAT) sb[i] <= '0;
          else                       sb[i] <= sb[i] - ONE;
        end
      end
      if (loadIssue) sb[id_rd] <= LAT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            stall_cnt <= '0;
    else if (stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_unit_hazard_scoreboard.sv
// Scoreboard bench: driver pushes expected stall/issue/count per cycle, negedge monitor compares.
// Four instances (latency 0..3) share stimulus; each expectation names the instance it targets.
module tb_unit_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       idValid, idMemread, idRsUsed, idRtUsed, flushIn;
  logic [4:0] idRd, idRs, idRt;

  logic stall0, stall1, stall2, stall3;
  logic issue0, issue1, issue2, issue3;
  logic [15:0] cnt0, cnt1, cnt3;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  int    selQ[$];
  int    expQ[$];
  string tagQ[$];

  always #5 clk = ~clk;

  unit_hazard_scoreboard #(.LOAD_LAT(0)) dutL0 (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_memread(idMemread), .id_rd(idRd),
    .id_rs(idRs), .id_rt(idRt), .id_rs_used(idRsUsed), .id_rt_used(idRtUsed), .flush(flushIn),
    .stall(stall0), .issue(issue0), .stall_cnt(cnt0));
  unit_hazard_scoreboard #(.LOAD_LAT(1)) dutL1 (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_memread(idMemread), .id_rd(idRd),
    .id_rs(idRs), .id_rt(idRt), .id_rs_used(idRsUsed), .id_rt_used(idRtUsed), .flush(flushIn),
    .stall(stall1), .issue(issue1), .stall_cnt(cnt1));
  unit_hazard_scoreboard #(.LOAD_LAT(2), .CNT_W(2)) dutL2 (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_memread(idMemread), .id_rd(idRd),
    .id_rs(idRs), .id_rt(idRt), .id_rs_used(idRsUsed), .id_rt_used(idRtUsed), .flush(flushIn),
    .stall(stall2), .issue(issue2), .stall_cnt(cnt2));
  unit_hazard_scoreboard #(.LOAD_LAT(3)) dutL3 (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_memread(idMemread), .id_rd(idRd),
    .id_rs(idRs), .id_rt(idRt), .id_rs_used(idRsUsed), .id_rt_used(idRtUsed), .flush(flushIn),
    .stall(stall3), .issue(issue3), .stall_cnt(cnt3));

  // Expected value packed as {stall, issue, count}.
  task automatic expect_out(input int sel, input bit st, input bit is, input int cnt,
                            input string tag);
    selQ.push_back(sel);
    expQ.push_back({st, is, cnt[15:0]});
    tagQ.push_back(tag);
  endtask

  task automatic cyc(input bit v, input bit mr, input int rd, input int rs, input int rt,
                     input bit rsu, input bit rtu, input bit fl);
    @(posedge clk);
    #1;
    idValid = v; idMemread = mr; idRd = rd[4:0]; idRs = rs[4:0]; idRt = rt[4:0];
    idRsUsed = rsu; idRtUsed = rtu; flushIn = fl;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idValid = 1'b0; idMemread = 1'b0; flushIn = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    while (selQ.size() > 0) begin
      int sel, exp, act;
      string tag;
      sel = selQ.pop_front();
      exp = expQ.pop_front();
      tag = tagQ.pop_front();
      case (sel)
        0:       act = {stall0, issue0, cnt0};
        1:       act = {stall1, issue1, cnt1};
        2:       act = {stall2, issue2, 14'd0, cnt2};
        default: act = {stall3, issue3, cnt3};
      endcase
      checks++;
      if (act != exp) begin
        errors++;
        $display("FAIL %s lat%0d: got stall=%0d issue=%0d cnt=%0d, want stall=%0d issue=%0d cnt=%0d",
                 tag, sel, act[17], act[16], act[15:0], exp[17], exp[16], exp[15:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idValid = 1'b0; idMemread = 1'b0; idRd = '0; idRs = '0; idRt = '0;
    idRsUsed = 1'b0; idRtUsed = 1'b0; flushIn = 1'b0;
    #1;
    expect_out(1, 0, 0, 0, "reset");
    expect_out(2, 0, 0, 0, "reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Classic single-cycle load-use, plus latency-0 never stalling.
    cyc(1, 1, 8, 1, 2, 1, 0, 0); expect_out(1, 0, 1, 0, "t1_lw");
    cyc(1, 0, 9, 8, 10, 1, 1, 0); expect_out(1, 1, 0, 0, "t1_use");
    expect_out(0, 0, 1, 0, "t1_lat0");
    cyc(1, 0, 9, 8, 10, 1, 1, 0); expect_out(1, 0, 1, 1, "t1_issue");
    cyc(0, 0, 0, 0, 0, 0, 0, 0); expect_out(1, 0, 0, 1, "t1_idle");

    // Three-cycle latency, then a self-referencing load.
    do_reset();
    cyc(1, 1, 5, 1, 2, 1, 0, 0); expect_out(3, 0, 1, 0, "t2_lw");
    cyc(1, 0, 9, 5, 2, 1, 0, 0); expect_out(3, 1, 0, 0, "t2_st1");
    cyc(1, 0, 9, 5, 2, 1, 0, 0); expect_out(3, 1, 0, 1, "t2_st2");
    cyc(1, 0, 9, 5, 2, 1, 0, 0); expect_out(3, 1, 0, 2, "t2_st3");
    cyc(1, 0, 9, 5, 2, 1, 0, 0); expect_out(3, 0, 1, 3, "t2_issue");
    cyc(1, 1, 6, 6, 2, 1, 0, 0); expect_out(3, 0, 1, 3, "t2_selfld");
    cyc(1, 1, 6, 6, 2, 1, 0, 0); expect_out(3, 1, 0, 3, "t2_olderld");

    // Zero register and unused operands.
    do_reset();
    cyc(1, 1, 0, 1, 2, 1, 0, 0); expect_out(1, 0, 1, 0, "t3_lw_r0");
    cyc(1, 0, 9, 0, 0, 1, 1, 0); expect_out(1, 0, 1, 0, "t3_use_r0");
    cyc(1, 1, 7, 1, 2, 1, 0, 0); expect_out(1, 0, 1, 0, "t3_lw_r7");
    cyc(1, 0, 9, 1, 7, 1, 0, 0); expect_out(1, 0, 1, 0, "t3_rt_unused");

    // Flush squashes the load that just entered ID/EX.
    do_reset();
    cyc(1, 1, 4, 1, 2, 1, 0, 0); expect_out(1, 0, 1, 0, "t4_lw"); expect_out(3, 0, 1, 0, "t4_lw");
    cyc(1, 0, 9, 4, 2, 1, 0, 1); expect_out(1, 0, 0, 0, "t4_flush"); expect_out(3, 0, 0, 0, "t4_flush");
    cyc(1, 0, 9, 4, 2, 1, 0, 0); expect_out(1, 0, 1, 0, "t4_after"); expect_out(3, 0, 1, 0, "t4_after");

    // Reload restarts the countdown; 2-bit counter saturates.
    do_reset();
    cyc(1, 1, 3, 1, 2, 1, 0, 0); expect_out(2, 0, 1, 0, "t5_lw");
    cyc(1, 0, 9, 1, 2, 1, 0, 0); expect_out(2, 0, 1, 0, "t5_indep");
    cyc(1, 1, 3, 1, 2, 1, 0, 0); expect_out(2, 0, 1, 0, "t5_reload");
    cyc(1, 0, 9, 3, 2, 1, 0, 0); expect_out(2, 1, 0, 0, "t5_st1");
    cyc(1, 0, 9, 3, 2, 1, 0, 0); expect_out(2, 1, 0, 1, "t5_st2");
    cyc(1, 0, 9, 3, 2, 1, 0, 0); expect_out(2, 0, 1, 2, "t5_issue");
    for (int r = 0; r < 2; r++) begin
      cyc(1, 1, 3, 1, 2, 1, 0, 0); expect_out(2, 0, 1, (r == 0) ? 2 : 3, "t6_lw");
      cyc(1, 0, 9, 1, 3, 0, 1, 0); expect_out(2, 1, 0, (r == 0) ? 2 : 3, "t6_sat_a");
      cyc(1, 0, 9, 1, 3, 0, 1, 0); expect_out(2, 1, 0, 3, "t6_sat_b");
      cyc(1, 0, 9, 1, 3, 0, 1, 0); expect_out(2, 0, 1, 3, "t6_sat_c");
    end

    // Asynchronous reset during a stall.
    do_reset();
    cyc(1, 1, 5, 1, 2, 1, 0, 0); expect_out(3, 0, 1, 0, "t7_lw");
    cyc(1, 0, 9, 5, 2, 1, 0, 0); expect_out(3, 1, 0, 0, "t7_stall");
    cyc(1, 0, 9, 5, 2, 1, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    expect_out(3, 0, 1, 0, "t7_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_out(3, 0, 1, 0, "t7_post");
    cyc(0, 0, 0, 0, 0, 0, 0, 0); expect_out(3, 0, 0, 0, "t7_idle");

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (selQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", selQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
